// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Round-robin arbiter that shares one native memory port between NREQ bus
// masters (instruction fetch, load/store, DMA/video). One requester is latched
// per transaction. Its address, write data and strobes are steered onto the
// memory port, and the completion handshake is returned to it. A watchdog
// aborts transactions that the slave never acknowledges.
//
// Ports
//   clk, resetn       clock; synchronous active-low reset
//   req_valid[NREQ]   per-requester request, held stable until its req_ready
//   req_addr          flattened addresses, requester i at [i*AW +: AW]
//   req_wdata         flattened write data, requester i at [i*DW +: DW]
//   req_wstrb         flattened byte strobes (all zero = read)
//   req_ready[NREQ]   one-hot completion pulse to the granted requester
//   req_rdata         read data broadcast to all requesters (valid with req_ready)
//   bus_err           set with req_ready when the watchdog aborted the access
//   mem_valid/addr/wdata/wstrb   memory request towards the slave
//   mem_ready/rdata   slave completion and read data
//
// Handshake: a requester raises req_valid and holds it, with all its fields
// stable, until the cycle in which its req_ready bit is 1; that cycle ends the
// transaction. On the memory side mem_valid stays high with stable fields
// until the cycle in which mem_ready is 1 (or the watchdog fires).

module mem_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    output logic [NREQ-1:0]        req_ready,
    output logic [DW-1:0]          req_rdata,
    output logic                   bus_err,
    output logic                   mem_valid,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [DW/8-1:0]        mem_wstrb,
    input  logic                   mem_ready,
    input  logic [DW-1:0]          mem_rdata
);

    localparam int          SW      = DW / 8;
    localparam bit          WD_EN   = (TIMEOUT != 0);
    // Watchdog count value during the final allowed BUSY cycle.
    localparam logic [15:0] WD_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant, grant_nxt;
    logic [1:0]  last, last_nxt;
    logic [15:0] wdog, wdog_nxt;

    logic        any_req;
    logic [1:0]  sel_idx;
    logic        timeout_hit;
    logic        done;

    // Round-robin pick: walk from the highest-offset candidate down to
    // last+1 so that the final overwrite is the highest-priority valid one.
    always_comb begin
        any_req = 1'b0;
        sel_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if ((j == ((int'(last) + k) % NREQ)) && req_valid[j]) begin
                    any_req = 1'b1;
                    sel_idx = 2'(j);
                end
            end
        end
    end

    // Field steering from the granted requester. grant is 0 after reset, so
    // the memory port follows requester 0 while idle.
    always_comb begin
        mem_addr  = req_addr[AW-1:0];
        mem_wdata = req_wdata[DW-1:0];
        mem_wstrb = req_wstrb[SW-1:0];
        for (int j = 1; j < NREQ; j++) begin
            if (grant == 2'(j)) begin
                mem_addr  = req_addr[j*AW +: AW];
                mem_wdata = req_wdata[j*DW +: DW];
                mem_wstrb = req_wstrb[j*SW +: SW];
            end
        end
    end

    assign req_rdata   = mem_rdata;
    assign timeout_hit = WD_EN && (wdog == WD_LAST);

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        wdog_nxt  = wdog;
        mem_valid = 1'b0;
        bus_err   = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = sel_idx;
                    wdog_nxt  = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    // A slave acknowledge always wins over a coincident timeout.
                    done      = 1'b1;
                    state_nxt = IDLE;
                    last_nxt  = grant;
                end else if (timeout_hit) begin
                    done      = 1'b1;
                    bus_err   = 1'b1;
                    state_nxt = IDLE;
                    last_nxt  = grant;
                end else if (wdog != 16'hFFFF) begin
                    wdog_nxt = wdog + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = done && (grant == 2'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            last  <= 2'(NREQ - 1);
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter sharing the single native memory port of the multicycle RV32IM SoC between up to four bus masters: CPU instruction fetch, CPU load/store, and DMA/video fetch. It latches one requester per transaction, steers that requester's address, write data and strobes onto the memory port, and returns the handshake to it. A watchdog counter aborts transactions the slave never acknowledges, so a dead peripheral cannot hang the core.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- AW, 32: address width.
- DW, 32: data width, a multiple of 8.
- TIMEOUT, 1024: cycles a granted transaction may wait for mem_ready before it is aborted. Legal range 1..65535; 0 disables the watchdog.

- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request; must be held stable until the matching req_ready.
- req_addr  in  NREQ*AW  flattened; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_wstrb  in  NREQ*(DW/8)  flattened byte strobes; all zero means read.
- req_ready  out  NREQ  one-hot completion pulse to the granted requester.
- req_rdata  out  DW  read data, broadcast to all requesters; valid only with req_ready.
- bus_err  out  1  high with req_ready when the transaction was aborted by the watchdog.
- mem_valid  out  1  memory request.
- mem_addr  out  AW  address of the granted requester.
- mem_wdata  out  DW  write data of the granted requester.
- mem_wstrb  out  DW/8  strobes of the granted requester.
- mem_ready  in  1  slave completion.
- mem_rdata  in  DW  slave read data.

## Operation
- FSM has two states: IDLE and BUSY. Registers: state, grant (2 bits), last (2 bits), wdog (16 bits).
- Reset values: state=IDLE, grant=0, last=NREQ-1 (requester 0 wins first), wdog=0. Outputs during and right after reset: mem_valid=0, req_ready=0, bus_err=0. mem_addr, mem_wdata and mem_wstrb follow requester 0's fields.
- **IDLE.** If any req_valid bit is set, select the first set bit scanning last+1, last+2, …, last+NREQ (mod NREQ). Then grant<=selected, wdog<=0, state<=BUSY. Otherwise stay in IDLE.
- **BUSY.**
  - mem_valid=1.
  - mem_addr, mem_wdata and mem_wstrb are a combinational mux of the granted requester's fields.
  - req_rdata=mem_rdata at all times.
- **BUSY, mem_ready=1.**
  - req_ready[grant]=1 combinationally in the same cycle; bus_err=0.
  - Next state IDLE, last<=grant.
- **BUSY, mem_ready=0, watchdog enabled, wdog==TIMEOUT-1.**
  - Abort: req_ready[grant]=1 and bus_err=1 in that cycle.
  - Next state IDLE, last<=grant.
  - mem_valid drops next cycle with no slave acknowledge.
- **BUSY otherwise.** wdog<=wdog+1; it saturates and never wraps.
- If mem_ready and the timeout condition occur in the same cycle, mem_ready wins: normal completion, bus_err=0.
- A requester dropping req_valid while granted is a protocol violation. The arbiter ignores it and keeps mem_valid high until ready or timeout.
- Non-granted requesters see req_ready=0 throughout. Their requests wait; they are never dropped.
- resetn low in BUSY forces IDLE at the next edge. The pending transaction gets no req_ready.

## Timing
- Arbitration latency is 1 cycle. req_valid first sampled high at edge N gives mem_valid high from cycle N+1.
- Minimum transaction is 2 cycles: arbitrate, then BUSY with mem_ready. There is one IDLE bubble between back-to-back grants, so peak throughput is one transaction per 2 cycles with a 1-cycle slave.
- req_ready, req_rdata and bus_err are combinational from mem_ready and mem_rdata in BUSY; there is no registered return path.
- An abort fires exactly TIMEOUT cycles after mem_valid rises, counting the first BUSY cycle as 1.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. Any requester waits at most NREQ-1 transactions.

## Test plan
- **Reset.** resetn low 3 cycles with req_valid=2'b11 → mem_valid=0, req_ready=0 during reset. After release, requester 0 is granted first and mem_valid rises 1 cycle after the first sampled edge.
- **Single read.** Requester 1 reads addr 0x0000_1000; slave returns 0xDEADBEEF with mem_ready 3 cycles after mem_valid → req_ready=2'b10 in exactly that cycle, req_rdata=0xDEADBEEF, bus_err=0.
- **Round robin.** NREQ=3, all valid, 1-cycle slave → grant sequence 0,1,2,0,1,2. mem_valid pattern is 1,0,1,0,… with the IDLE bubble.
- **Write steering.** Requester 0 writes 0x12345678 with wstrb=4'b0011 to 0x40 while requester 1 waits → mem_wdata, mem_wstrb and mem_addr match requester 0 exactly. Requester 1 is granted next.
- **Timeout.** TIMEOUT=8, slave never ready → req_ready and bus_err pulse for 1 cycle in the 8th BUSY cycle, then mem_valid=0. Same-cycle mem_ready at cycle 8 → bus_err=0.
- **Mid-transaction reset.** resetn low in cycle 2 of BUSY → no req_ready; mem_valid=0 after the edge. Arbitration restarts from requester 0.
